// File: rtl/exec_unit_if.sv
// Handshake and register-file write bundle between the sequencer (master) and the execute stage (slave).
interface exec_unit_if #(
  parameter int WIDTH = 32,
  parameter int SELW  = 5
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [SELW-1:0]  dst;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             wr;
  logic [SELW-1:0]  selwr;
  logic [WIDTH-1:0] wdata;

  modport master (
    output start, op, a, b, dst,
    input  busy, done, result, wr, selwr, wdata
  );

  modport slave (
    input  start, op, a, b, dst,
    output busy, done, result, wr, selwr, wdata
  );
endinterface

// File: rtl/exec_unit.sv
// RV32 integer execute stage: single-cycle ALU ops (latency 1), iterative MUL/MULHU/DIVU/REMU (latency 33).
// One op in flight; start is ignored while busy, result is written to the register file for one cycle.
module exec_unit #(
  parameter int WIDTH = 32,
  parameter int SELW  = 5
) (
  input logic       clk,
  input logic       rst,
  exec_unit_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         r_state;
  logic [4:0]         r_cnt;
  logic               r_div;
  logic               r_hi;
  logic [WIDTH-1:0]   r_opnd;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_result;
  logic [SELW-1:0]    r_selwr;
  logic               r_wr;
  logic               r_done;
  logic               r_busy;

  logic               w_iter;
  logic [WIDTH-1:0]   w_alu;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_rsh;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_mul_nxt;
  logic [2*WIDTH-1:0] w_div_nxt;
  logic [2*WIDTH-1:0] w_nxt;

  assign w_iter = (bus.op >= 4'd10) && (bus.op <= 4'd13);

  always_comb begin
    w_alu = '0;
    case (bus.op)
      4'd0:    w_alu = bus.a + bus.b;
      4'd1:    w_alu = bus.a - bus.b;
      4'd2:    w_alu = bus.a & bus.b;
      4'd3:    w_alu = bus.a | bus.b;
      4'd4:    w_alu = bus.a ^ bus.b;
      4'd5:    w_alu = bus.a << bus.b[4:0];
      4'd6:    w_alu = bus.a >> bus.b[4:0];
      4'd7:    w_alu = $signed(bus.a) >>> bus.b[4:0];
      4'd8:    w_alu = {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
      4'd9:    w_alu = {{(WIDTH-1){1'b0}}, bus.a < bus.b};
      default: w_alu = '0;
    endcase
  end

  // Accumulator is {hi, lo}: multiply keeps {partial product, multiplier},
  // divide keeps {remainder, dividend/quotient}; both shift one bit per step.
  assign w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opnd};
  assign w_mul_nxt = r_acc[0] ? {w_sum, r_acc[WIDTH-1:1]}
                              : {1'b0, r_acc[2*WIDTH-1:1]};

  assign w_rsh     = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_diff    = w_rsh - {1'b0, r_opnd};
  assign w_div_nxt = w_diff[WIDTH] ? {w_rsh[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b0}
                                   : {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  assign w_nxt = r_div ? w_div_nxt : w_mul_nxt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_div    <= 1'b0;
      r_hi     <= 1'b0;
      r_opnd   <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_selwr  <= '0;
      r_wr     <= 1'b0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_selwr <= bus.dst;
            r_busy  <= 1'b1;
            if (w_iter) begin
              r_div   <= bus.op[2];
              r_hi    <= bus.op[0];
              r_opnd  <= bus.op[2] ? bus.b : bus.a;
              r_acc   <= {{WIDTH{1'b0}}, (bus.op[2] ? bus.a : bus.b)};
              r_cnt   <= '0;
              r_state <= S_RUN;
            end else begin
              r_result <= w_alu;
              r_wr     <= (bus.dst != '0);
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end
          end
        end
        S_RUN: begin
          r_acc <= w_nxt;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            r_result <= r_hi ? w_nxt[2*WIDTH-1:WIDTH] : w_nxt[WIDTH-1:0];
            r_wr     <= (r_selwr != '0);
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_wr    <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_wr    <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;
  assign bus.wdata  = r_result;
  assign bus.wr     = r_wr;
  assign bus.selwr  = r_selwr;

endmodule

// File: tb/tb_exec_unit.sv
// Randomized and directed bench for exec_unit against an arithmetic reference model.
module tb_exec_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  exec_unit_if #(.WIDTH(32), .SELW(5)) bus ();

  exec_unit #(.WIDTH(32), .SELW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return a << b[4:0];
      4'd6:  return a >> b[4:0];
      4'd7:  return 32'($signed(a) >>> b[4:0]);
      4'd8:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:  return (a < b) ? 32'd1 : 32'd0;
      4'd10: return p[31:0];
      4'd11: return p[63:32];
      4'd12: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd13: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  // hold=1 keeps start high with scrambled inputs through RUN and DONE.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] dst, input bit hold);
    logic [31:0] exp;
    int          exp_lat;
    int          lat;
    exp     = ref_model(op, a, b);
    exp_lat = (op >= 4'd10 && op <= 4'd13) ? 33 : 1;
    lat     = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.dst   = dst;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (hold) begin
        bus.op  = 4'($urandom);
        bus.a   = $urandom;
        bus.b   = $urandom;
        bus.dst = 5'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        lat = c;
        break;
      end
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("result", bus.result, exp);
    chk("wdata", bus.wdata, exp);
    chk("selwr", 32'(bus.selwr), 32'(dst));
    chk("wr", 32'(bus.wr), (dst != 5'd0) ? 32'd1 : 32'd0);
    chk("busy_in_done", 32'(bus.busy), 32'd1);
    @(negedge clk);
    bus.start = 1'b0;
    chk("done_one_cycle", 32'(bus.done), 32'd0);
    chk("idle_after", 32'(bus.busy), 32'd0);
    chk("wr_one_cycle", 32'(bus.wr), 32'd0);
    chk("result_held", bus.result, exp);
  endtask

  initial begin
    int seen;
    bus.start = 1'b0;
    bus.op    = '0;
    bus.a     = '0;
    bus.b     = '0;
    bus.dst   = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_wr", 32'(bus.wr), 32'd0);
    chk("rst_selwr", 32'(bus.selwr), 32'd0);
    chk("rst_result", bus.result, 32'd0);
    rst = 1'b1;

    do_op(4'd0,  32'd5,          32'd7,          5'd3,  1'b0);
    do_op(4'd1,  32'd0,          32'd1,          5'd4,  1'b0);
    do_op(4'd7,  32'h8000_0000,  32'h24,         5'd5,  1'b0);
    do_op(4'd6,  32'h8000_0000,  32'h24,         5'd6,  1'b0);
    do_op(4'd8,  32'hFFFF_FFFF,  32'd1,          5'd7,  1'b0);
    do_op(4'd9,  32'hFFFF_FFFF,  32'd1,          5'd8,  1'b0);
    do_op(4'd10, 32'h1234_5678,  32'h10,         5'd9,  1'b0);
    do_op(4'd11, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd10, 1'b0);
    do_op(4'd12, 32'd100,        32'd7,          5'd11, 1'b0);
    do_op(4'd13, 32'd100,        32'd7,          5'd12, 1'b0);
    do_op(4'd12, 32'hDEAD_BEEF,  32'd0,          5'd13, 1'b0);
    do_op(4'd13, 32'h1234,       32'd0,          5'd14, 1'b0);
    do_op(4'd0,  32'd9,          32'd9,          5'd0,  1'b0);
    do_op(4'd10, 32'h0000_0003,  32'h0000_0005,  5'd15, 1'b1);
    do_op(4'd4,  32'hA5A5_A5A5,  32'h0F0F_0F0F,  5'd16, 1'b1);
    do_op(4'd14, 32'h1,          32'h2,          5'd17, 1'b0);

    // Abort a divide partway through with reset.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 4'd12;
    bus.a     = 32'd1000;
    bus.b     = 32'd3;
    bus.dst   = 5'd9;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_wr", 32'(bus.wr), 32'd0);
    chk("abort_selwr", 32'(bus.selwr), 32'd0);
    chk("abort_wdata", bus.wdata, 32'd0);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.done || bus.wr || bus.busy) seen++;
    end
    chk("abort_quiet", 32'(seen), 32'd0);
    do_op(4'd0, 32'd1, 32'd1, 5'd5, 1'b0);

    for (int i = 0; i < 60; i++) begin
      logic [31:0] ra, rb;
      int          mode;
      ra   = $urandom;
      mode = $urandom_range(0, 3);
      rb   = (mode == 0) ? 32'd0 : (mode == 1) ? 32'($urandom_range(1, 40)) : $urandom;
      do_op(4'($urandom_range(0, 15)), ra, rb, 5'($urandom_range(0, 31)),
            ($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/exec_unit.md
# exec_unit

Execute stage placed directly downstream of the register file. Takes the two registered read operands and a destination index, computes one RV32 integer result (single-cycle ALU ops, 32-cycle iterative multiply/divide), and drives the register file write port (`wr`, `selwr`, `wdata`) for exactly one cycle per completed operation. A start/busy/done handshake lets the sequencer issue one operation at a time.

## Interface
- `WIDTH`, 32: datapath width; only 32 is supported.
- `SELW`, 5: register index width.

- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  synchronous reset, active-low (`rst`=0 resets on the next rising edge)
- `start`  in  1  launch request; sampled only while `busy`=0
- `op`  in  4  operation code, latched with `start`
- `a`, `b`  in  WIDTH  operands (register file `out1`/`out2`), latched with `start`
- `dst`  in  SELW  destination register, latched with `start`
- `busy`  out  1  high in RUN and DONE
- `done`  out  1  one-cycle completion pulse
- `result`  out  WIDTH  last completed result, held until the next completion
- `wr`  out  1  register file write enable
- `selwr`  out  SELW  write index (latched `dst`)
- `wdata`  out  WIDTH  write data (equals `result`)

## Operation
- Op codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT (signed), 9 SLTU, 10 MUL (low 32), 11 MULHU (high 32, unsigned), 12 DIVU, 13 REMU; 14 and 15 are reserved and produce 0.
- Arithmetic is modulo 2^32. Shift amount is `b[4:0]`. SLT/SLTU produce 0 or 1.
- FSM states: IDLE, RUN, DONE.
  - IDLE, `start`=1, op is not 10–13: compute the result and go to DONE.
  - IDLE, `start`=1, op is 10–13: latch operands, clear step counter, go to RUN.
  - RUN: one step per cycle. MUL/MULHU use shift-add on a 64-bit accumulator. DIVU/REMU use restoring division on a 32-bit remainder and quotient. After step 31, go to DONE.
  - DONE: `done`=1 for one cycle, then go to IDLE.
- `wr`=1 in DONE only when latched `dst`≠0. Register x0 is never written, but `done` still pulses.
- Divide by zero: DIVU returns 0xFFFFFFFF and REMU returns the dividend. No trap. Still takes 32 steps.
- `start` while `busy`=1, including during the DONE cycle, is ignored with no side effect.
- Inputs `a`, `b`, `op`, `dst` may change freely after the start cycle.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `wr` 0, `selwr` 0, `result`/`wdata` 0, counter 0.
- All outputs are registered and change only on rising `clk`.
- Single-cycle op with `start` sampled at edge k: `done`, `wr`, `selwr`, `wdata` valid in the cycle after edge k; `busy` high for that same cycle.
- Iterative op with `start` sampled at edge k: RUN covers edges k+1..k+32; DONE is in the cycle after edge k+32 (latency 33). `busy` is high from after edge k through the DONE cycle.
- Maximum issue rate: one op per 2 cycles (single-cycle ops); one per 34 cycles (iterative ops).
- Register file sees the write at the edge ending the DONE cycle. The register file's read output is registered, so the sequencer must assert `rd` one cycle before `start`.
- Reset asserted in any state, including mid-RUN: the next edge returns to IDLE with all outputs at reset values. The aborted op produces no `done` and no `wr`.
- `rst`=0 overrides a simultaneous `start`.

## Test plan
- ADD a=5, b=7, dst=3 -> one cycle later `done`=1, `wr`=1, `selwr`=3, `wdata`=12. SUB a=0, b=1 -> 0xFFFFFFFF.
- SRA a=0x80000000, b=0x24 (shift 4) -> 0xF8000000. SRL with the same operands -> 0x08000000. SLT a=0xFFFFFFFF, b=1 -> 1. SLTU with the same operands -> 0.
- MUL 0x12345678×0x10 -> 0x23456780 with `done` exactly 33 cycles after start. MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE.
- DIVU 100/7 -> 14; REMU 100/7 -> 2. DIVU x/0 -> 0xFFFFFFFF; REMU 0x1234/0 -> 0x1234.
- ADD with dst=0 -> `done` pulses, `wr` stays 0. `start` held high during RUN and DONE with different op/a/b -> ignored, original result is written.
- `rst`=0 at step 10 of DIVU -> next cycle all outputs are 0 and `busy`=0, no write occurs. A following ADD 1+1 completes normally with result 2.
